// File: rtl/biu_sequencer.sv
// Bus interface sequencer: arbitrates EU data cycles against instruction prefetch
// and splits odd-aligned word accesses into two byte-lane bus cycles.
module biu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        eu_req,
    input  logic        eu_we,
    input  logic        eu_word,
    input  logic [15:0] eu_addr,
    input  logic [15:0] eu_wdata,
    output logic        eu_ack,
    output logic [15:0] eu_rdata,
    input  logic        q_full,
    input  logic [15:0] q_pfp,
    output logic        q_push,
    output logic [15:0] q_data,
    output logic        q_flush,
    output logic [15:0] q_new_pfp,
    input  logic        flush,
    input  logic [15:0] flush_addr,
    output logic [15:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, FETCH, EU_LO, EU_HI} state_t;

    state_t      state;
    logic        discard;
    logic        flush_d;
    logic        lat_we;
    logic        lat_word;
    logic [15:0] lat_addr;
    logic [7:0]  lat_wdata_hi;
    logic [7:0]  lo_byte;

    logic        eu_start_c;
    logic        fetch_start_c;
    logic        lat_odd_word_c;
    logic [1:0]  eu_be_c;
    logic [15:0] eu_lane_c;
    logic [15:0] eu_lo_rdata_c;

    assign q_flush   = flush;
    assign q_new_pfp = flush_addr;

    // A pending eu_req is ignored while eu_ack is high: it is the request just served.
    assign eu_start_c     = eu_req && !eu_ack;
    assign fetch_start_c  = !eu_req && !q_full && !flush && !flush_d;
    assign lat_odd_word_c = lat_word && lat_addr[0];

    // First EU bus cycle lanes, computed from the live request on leaving IDLE.
    always_comb begin
        eu_be_c   = 2'b01;
        eu_lane_c = {8'h00, eu_wdata[7:0]};
        if (eu_addr[0]) begin
            eu_be_c   = 2'b10;
            eu_lane_c = {eu_wdata[7:0], 8'h00};
        end else if (eu_word) begin
            eu_be_c   = 2'b11;
            eu_lane_c = eu_wdata;
        end
    end

    // Read return for a single-cycle EU access.
    always_comb begin
        eu_lo_rdata_c = {8'h00, mem_rdata[7:0]};
        if (lat_addr[0])
            eu_lo_rdata_c = {8'h00, mem_rdata[15:8]};
        else if (lat_word)
            eu_lo_rdata_c = mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            discard      <= 1'b0;
            flush_d      <= 1'b0;
            lat_we       <= 1'b0;
            lat_word     <= 1'b0;
            lat_addr     <= 16'h0000;
            lat_wdata_hi <= 8'h00;
            lo_byte      <= 8'h00;
            eu_ack       <= 1'b0;
            eu_rdata     <= 16'h0000;
            q_push       <= 1'b0;
            q_data       <= 16'h0000;
            mem_addr     <= 16'h0000;
            mem_be       <= 2'b00;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wdata    <= 16'h0000;
        end else begin
            flush_d <= flush;
            q_push  <= 1'b0;
            eu_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (eu_start_c) begin
                        state        <= EU_LO;
                        lat_we       <= eu_we;
                        lat_word     <= eu_word;
                        lat_addr     <= eu_addr;
                        lat_wdata_hi <= eu_wdata[15:8];
                        mem_addr     <= eu_addr;
                        mem_be       <= eu_be_c;
                        mem_wdata    <= eu_lane_c;
                        mem_rd       <= !eu_we;
                        mem_wr       <= eu_we;
                    end else if (fetch_start_c) begin
                        state    <= FETCH;
                        mem_addr <= q_pfp;
                        mem_be   <= q_pfp[0] ? 2'b10 : 2'b11;
                        mem_rd   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (flush)
                        discard <= 1'b1;
                    // A flushed fetch still runs to completion but its data is dropped.
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_rd  <= 1'b0;
                        discard <= 1'b0;
                        q_push  <= !discard && !flush;
                        q_data  <= mem_addr[0] ? {8'h00, mem_rdata[15:8]} : mem_rdata;
                    end
                end
                EU_LO: begin
                    if (mem_ready) begin
                        if (lat_odd_word_c) begin
                            state     <= EU_HI;
                            mem_addr  <= lat_addr + 16'd1;
                            mem_be    <= 2'b01;
                            mem_wdata <= {8'h00, lat_wdata_hi};
                            lo_byte   <= mem_rdata[15:8];
                        end else begin
                            state  <= IDLE;
                            mem_rd <= 1'b0;
                            mem_wr <= 1'b0;
                            eu_ack <= 1'b1;
                            if (!lat_we)
                                eu_rdata <= eu_lo_rdata_c;
                        end
                    end
                end
                EU_HI: begin
                    if (mem_ready) begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        eu_ack <= 1'b1;
                        if (!lat_we)
                            eu_rdata <= {mem_rdata[7:0], lo_byte};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_biu_sequencer.sv
// Scoreboard bench for biu_sequencer: directed EU/prefetch/flush/reset vectors
// against a wait-state memory model; a negedge monitor checks bus cycles and pulses.
module tb_biu_sequencer;

    typedef struct packed {
        logic        is_ack;
        logic        chk_data;
        logic [15:0] data;
    } ev_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } bus_t;

    logic        clk;
    logic        reset;
    logic        eu_req, eu_we, eu_word;
    logic [15:0] eu_addr, eu_wdata;
    logic        eu_ack;
    logic [15:0] eu_rdata;
    logic        q_full;
    logic [15:0] q_pfp;
    logic        q_push;
    logic [15:0] q_data;
    logic        q_flush;
    logic [15:0] q_new_pfp;
    logic        flush;
    logic [15:0] flush_addr;
    logic [15:0] mem_addr;
    logic [1:0]  mem_be;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;
    int ready_wait = 0;
    int wait_cnt = 0;

    ev_t  ev_q[$];
    bus_t bus_q[$];
    logic [15:0] tbl[logic [15:0]];

    biu_sequencer dut (
        .clk(clk), .reset(reset),
        .eu_req(eu_req), .eu_we(eu_we), .eu_word(eu_word),
        .eu_addr(eu_addr), .eu_wdata(eu_wdata),
        .eu_ack(eu_ack), .eu_rdata(eu_rdata),
        .q_full(q_full), .q_pfp(q_pfp), .q_push(q_push), .q_data(q_data),
        .q_flush(q_flush), .q_new_pfp(q_new_pfp),
        .flush(flush), .flush_addr(flush_addr),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lookup(input logic [15:0] a);
        if (tbl.exists(a))
            return tbl[a];
        return 16'hDEAD;
    endfunction

    // Memory: ready_wait idle cycles per bus cycle, data chosen by byte address.
    always @(posedge clk) begin
        #2;
        if (!(mem_rd || mem_wr) || mem_ready)
            wait_cnt = 0;
        mem_ready = (mem_rd || mem_wr) && (wait_cnt >= ready_wait);
        if ((mem_rd || mem_wr) && !mem_ready)
            wait_cnt++;
        mem_rdata = lookup(mem_addr);
    end

    // Monitor: every completed bus cycle and every push/ack must match the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (q_push || eu_ack)
                chk("push_ack_exclusive", 32'(q_push && eu_ack), 32'd0);
            if ((mem_rd || mem_wr) && mem_ready) begin
                chk("bus_expected", 32'(bus_q.size() != 0), 32'd1);
                if (bus_q.size() != 0) begin
                    bus_t b;
                    b = bus_q.pop_front();
                    chk("bus_wr_be_addr", {13'd0, mem_wr, mem_be, mem_addr}, {13'd0, b.wr, b.be, b.addr});
                    chk("bus_dir", 32'(mem_rd ^ mem_wr), 32'd1);
                    if (b.wr)
                        chk("bus_wdata", 32'(mem_wdata), 32'(b.wdata));
                end
            end
            if (q_push || eu_ack) begin
                chk("event_expected", 32'(ev_q.size() != 0), 32'd1);
                if (ev_q.size() != 0) begin
                    ev_t e;
                    e = ev_q.pop_front();
                    chk("event_kind", 32'(eu_ack), 32'(e.is_ack));
                    if (e.chk_data)
                        chk(e.is_ack ? "eu_rdata" : "q_data", 32'(e.is_ack ? eu_rdata : q_data), 32'(e.data));
                end
            end
        end
    end

    task automatic exp_bus(input logic wr, input logic [15:0] addr, input logic [1:0] be, input logic [15:0] wd);
        bus_t b;
        b.wr = wr; b.addr = addr; b.be = be; b.wdata = wd;
        bus_q.push_back(b);
    endtask

    task automatic exp_ev(input logic is_ack, input logic cd, input logic [15:0] d);
        ev_t e;
        e.is_ack = is_ack; e.chk_data = cd; e.data = d;
        ev_q.push_back(e);
    endtask

    task automatic eu_op(input logic we, input logic word, input logic [15:0] addr, input logic [15:0] wd);
        int n;
        eu_we = we; eu_word = word; eu_addr = addr; eu_wdata = wd; eu_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!eu_ack && n < 60);
        if (!eu_ack)
            chk("eu_ack_timeout", 32'(eu_ack), 32'd1);
        eu_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [15:0] pfp);
        q_pfp = pfp;
        q_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        q_full = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        eu_req = 1'b0; eu_we = 1'b0; eu_word = 1'b0; eu_addr = 16'h0; eu_wdata = 16'h0;
        q_full = 1'b1; q_pfp = 16'h0; flush = 1'b0; flush_addr = 16'h0;
        tbl[16'h0010] = 16'hBEEF;
        tbl[16'h0011] = 16'h12AB;
        tbl[16'h0020] = 16'h4444;
        tbl[16'h0030] = 16'h1357;
        tbl[16'h0040] = 16'h2468;
        tbl[16'h0101] = 16'h3400;
        tbl[16'h0102] = 16'h0056;
        tbl[16'h0200] = 16'hCAFE;
        tbl[16'h0201] = 16'h7788;
        tbl[16'h0202] = 16'h7788;
        tbl[16'hFFFF] = 16'h9A00;
        tbl[16'h0000] = 16'h00BC;
        tbl[16'h0501] = 16'h1100;
        repeat (3) @(negedge clk);
        chk("reset_mem_rd_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("reset_push_ack", {30'd0, q_push, eu_ack}, 32'd0);
        chk("reset_eu_rdata", 32'(eu_rdata), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_q_full_no_fetch", 32'(mem_rd), 32'd0);

        // Even and odd prefetch.
        exp_bus(1'b0, 16'h0010, 2'b11, 16'h0); exp_ev(1'b0, 1'b1, 16'hBEEF);
        do_fetch(16'h0010);
        exp_bus(1'b0, 16'h0011, 2'b10, 16'h0); exp_ev(1'b0, 1'b1, 16'h0012);
        do_fetch(16'h0011);

        // Flush in the second wait cycle of a fetch: cycle completes, no push.
        ready_wait = 3;
        q_pfp = 16'h0020;
        exp_bus(1'b0, 16'h0020, 2'b11, 16'h0);
        q_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        q_full = 1'b1;
        @(negedge clk);
        flush = 1'b1; flush_addr = 16'h0400;
        #1;
        chk("q_flush_pass", 32'(q_flush), 32'd1);
        chk("q_new_pfp_pass", 32'(q_new_pfp), 32'h0400);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("q_flush_drop", 32'(q_flush), 32'd0);
        repeat (5) @(negedge clk);
        ready_wait = 0;

        // Flush in IDLE blocks fetch for that cycle and the one after.
        q_pfp = 16'h0040;
        exp_bus(1'b0, 16'h0040, 2'b11, 16'h0); exp_ev(1'b0, 1'b1, 16'h2468);
        flush = 1'b1; q_full = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("no_fetch_on_flush", 32'(mem_rd), 32'd0);
        @(negedge clk);
        chk("no_fetch_after_flush", 32'(mem_rd), 32'd0);
        @(negedge clk);
        chk("fetch_resumes", 32'(mem_rd), 32'd1);
        q_full = 1'b1;
        repeat (3) @(negedge clk);

        // Odd word read, split over two cycles.
        exp_bus(1'b0, 16'h0101, 2'b10, 16'h0); exp_bus(1'b0, 16'h0102, 2'b01, 16'h0);
        exp_ev(1'b1, 1'b1, 16'h5634);
        eu_op(1'b0, 1'b1, 16'h0101, 16'h0);
        repeat (3) @(negedge clk);

        // EU wins arbitration, prefetch follows.
        q_pfp = 16'h0030;
        exp_bus(1'b0, 16'h0200, 2'b11, 16'h0); exp_ev(1'b1, 1'b1, 16'hCAFE);
        exp_bus(1'b0, 16'h0030, 2'b11, 16'h0); exp_ev(1'b0, 1'b1, 16'h1357);
        q_full = 1'b0;
        eu_op(1'b0, 1'b1, 16'h0200, 16'h0);
        @(posedge clk);
        @(negedge clk);
        q_full = 1'b1;
        repeat (3) @(negedge clk);
        chk("q_full_holds_off", 32'(mem_rd), 32'd0);

        // Writes: aligned word, even byte, odd byte, odd word.
        exp_bus(1'b1, 16'h0300, 2'b11, 16'hA1B2); exp_ev(1'b1, 1'b0, 16'h0);
        eu_op(1'b1, 1'b1, 16'h0300, 16'hA1B2);
        exp_bus(1'b1, 16'h0304, 2'b01, 16'h00C3); exp_ev(1'b1, 1'b0, 16'h0);
        eu_op(1'b1, 1'b0, 16'h0304, 16'hFFC3);
        exp_bus(1'b1, 16'h0305, 2'b10, 16'hD400); exp_ev(1'b1, 1'b0, 16'h0);
        eu_op(1'b1, 1'b0, 16'h0305, 16'hEED4);
        exp_bus(1'b1, 16'h0401, 2'b10, 16'h6600); exp_bus(1'b1, 16'h0402, 2'b01, 16'h0055);
        exp_ev(1'b1, 1'b0, 16'h0);
        eu_op(1'b1, 1'b1, 16'h0401, 16'h5566);

        // Byte reads and odd word wrapping past FFFF.
        exp_bus(1'b0, 16'h0202, 2'b01, 16'h0); exp_ev(1'b1, 1'b1, 16'h0088);
        eu_op(1'b0, 1'b0, 16'h0202, 16'h0);
        exp_bus(1'b0, 16'h0201, 2'b10, 16'h0); exp_ev(1'b1, 1'b1, 16'h0077);
        eu_op(1'b0, 1'b0, 16'h0201, 16'h0);
        exp_bus(1'b0, 16'hFFFF, 2'b10, 16'h0); exp_bus(1'b0, 16'h0000, 2'b01, 16'h0);
        exp_ev(1'b1, 1'b1, 16'hBC9A);
        eu_op(1'b0, 1'b1, 16'hFFFF, 16'h0);
        repeat (2) @(negedge clk);

        // Reset while the second half of an odd word is outstanding.
        ready_wait = 4;
        exp_bus(1'b0, 16'h0501, 2'b10, 16'h0);
        eu_we = 1'b0; eu_word = 1'b1; eu_addr = 16'h0501; eu_req = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(mem_rd && mem_addr == 16'h0502) && n < 40);
            chk("reached_eu_hi", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h0502});
        end
        reset = 1'b1;
        #1;
        chk("reset_drops_bus", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("reset_no_ack", 32'(eu_ack), 32'd0);
        eu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ready_wait = 0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", {30'd0, mem_rd, mem_wr}, 32'd0);

        repeat (3) @(negedge clk);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("ev_q_drained", 32'(ev_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/biu_sequencer.md
BIU_SEQUENCER -- requirements
Module: biu_sequencer

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-002 SHALL have EU ports: eu_req in 1 request, held until eu_ack; eu_we in 1 (1=write); eu_word in 1 (1=16-bit, 0=8-bit); eu_addr in 16 byte address; eu_wdata in 16; eu_ack out 1 one-cycle done pulse; eu_rdata out 16, valid with eu_ack.
REQ-003 SHALL have queue ports: q_full in 1; q_pfp in 16 queue fetch pointer; q_push out 1; q_data out 16; q_flush out 1; q_new_pfp out 16.
REQ-004 SHALL have jump ports: flush in 1 one-cycle jump strobe; flush_addr in 16 jump target.
REQ-005 SHALL have memory ports: mem_addr out 16; mem_be out 2 ([0]=even byte, [1]=odd byte); mem_rd out 1; mem_wr out 1; mem_wdata out 16; mem_rdata in 16; mem_ready in 1.

Function
REQ-006 SHALL use FSM states IDLE, FETCH, EU_LO, EU_HI; only FETCH/EU_LO/EU_HI drive bus cycles.
REQ-007 SHALL hold mem_rd or mem_wr high with stable mem_addr/mem_be/mem_wdata for the whole bus state; a cycle completes on the posedge where mem_ready=1, sampling mem_rdata there.
REQ-008 SHALL arbitrate in IDLE: eu_req wins over prefetch; fetch starts only if !eu_req, !q_full, no flush this cycle, no flush previous cycle.
REQ-009 SHALL, in FETCH, drive mem_addr=q_pfp, mem_be=2'b11 if q_pfp[0]=0 else 2'b10, mem_rd=1.
REQ-010 SHALL, on FETCH completion, pulse q_push one cycle with q_data=mem_rdata (even pfp) or {8'h00,mem_rdata[15:8]} (odd pfp), then return to IDLE.
REQ-011 SHALL pass flush combinationally: q_flush=flush, q_new_pfp=flush_addr.
REQ-012 SHALL, on flush during FETCH (including the completion cycle), set a discard flag: the outstanding cycle still waits for mem_ready, q_push is suppressed, flag clears on return to IDLE.
REQ-013 SHALL not interrupt EU cycles on flush.
REQ-014 SHALL latch eu_we/eu_word/eu_addr/eu_wdata on leaving IDLE for EU_LO.
REQ-015 SHALL, in EU_LO, drive mem_addr=addr; be=2'b11 for aligned word, 2'b01 for even byte, 2'b10 for odd byte or odd word.
REQ-016 SHALL place write data on lanes: aligned word as-is; even byte {8'h00,d[7:0]}; odd byte/odd-word low {d[7:0],8'h00}.
REQ-017 SHALL handle odd word as two cycles: EU_LO then EU_HI at addr+1 (16-bit wrap, FFFF->0000), be=2'b01, write lane {8'h00,d[15:8]}.
REQ-018 SHALL return eu_rdata: aligned word = mem_rdata; byte = zero-extended selected lane; odd word = {EU_HI lane[7:0], EU_LO lane[15:8]}.
REQ-019 SHALL pulse eu_ack on the final-cycle completion edge +0 (registered, high the cycle after that edge), return to IDLE, and not restart an EU cycle while eu_ack is high.
REQ-020 SHALL keep q_push and eu_ack mutually exclusive.

Reset
REQ-021 SHALL on reset (asynchronous) set state=IDLE, discard flag=0, flush-history=0, eu_ack=0, q_push=0, mem_rd=0, mem_wr=0, eu_rdata=0, latched EU fields=0; reset mid-bus-cycle abandons it without push/ack.

Verification
REQ-022 Fetch: q_pfp=0x0010, q_full=0, mem_ready=1, mem_rdata=0xBEEF -> mem_rd, be=11, q_push with q_data=0xBEEF.
REQ-023 Odd fetch: q_pfp=0x0011, mem_rdata=0x12AB -> be=10, q_data=0x0012.
REQ-024 Flush mid-fetch: mem_ready held 0 three cycles, flush=1 flush_addr=0x0400 in cycle 2 -> q_flush pulse, no q_push on completion, no fetch the following cycle.
REQ-025 Odd word read: eu_addr=0x0101 word, mem_rdata 0x3400 then 0x0056 -> two cycles addr 0x0101/0x0102, eu_rdata=0x5634, one eu_ack.
REQ-026 Arbitration: eu_req and fetch eligible same cycle -> EU cycle first, fetch next; q_full=1 -> no fetch.
REQ-027 Reset asserted during EU_HI -> mem_rd/mem_wr drop immediately, no eu_ack, IDLE after release.
